// File: rtl/sd_arbiter_pkg.sv
// Shared definitions for the SD word-reader arbiter: FSM state codes, port indices, grant constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_arbiter_pkg;

    // 3-bit state encoding; IDLE must stay 0 so the debug output reads 0 out of reset.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_LESEN    = 3'd2,
        ST_NACHLAUF = 3'd3,
        ST_TREFFER  = 3'd4
    } zustand_t;

    // Bit positions inside the one-hot Aktiv vector.
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    localparam logic [1:0] AKTIV_KEINER = 2'b00;
    localparam logic [1:0] AKTIV_A      = 2'b01;
    localparam logic [1:0] AKTIV_B      = 2'b10;

    // One-hot grant vector for the selected port.
    function automatic logic [1:0] aktiv_von(input logic port_b);
        return port_b ? AKTIV_B : AKTIV_A;
    endfunction

endpackage

// File: rtl/sd_arbiter_anfrage.sv
// Per-port read request buffer: holds one pending word address until the arbiter takes it.
// Latency: a Lesen pulse in cycle 0 shows up as pending in cycle 1.
// Backpressure: busy = pending | granted; a Lesen pulse while busy is dropped silently.
//
// Ports: Clock/Reset (async active-low); lesen/adresse request from the port;
//        freigabe clears pending when the arbiter grants this port;
//        gewaehrt marks this port as the one currently being served;
//        pending/adr feed the arbiter, busy goes back to the requester.
module sd_arbiter_anfrage (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        lesen,
    input  logic [31:0] adresse,
    input  logic        freigabe,
    input  logic        gewaehrt,
    output logic        pending,
    output logic [31:0] adr,
    output logic        busy
);

    assign busy = pending | gewaehrt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pending <= 1'b0;
            adr     <= 32'd0;
        end else if (freigabe) begin
            // freigabe only happens while pending, so busy is high and no
            // new request can be captured in the same cycle.
            pending <= 1'b0;
        end else if (lesen && !busy) begin
            pending <= 1'b1;
            adr     <= adresse;
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one SD word-reader between port A (CPU) and port B (loader/DMA).
// Latency: Lesen in cycle 0 -> SD_Lesen in cycle 2; SD_Fertig first high in cycle N -> X_Fertig in N+1.
// Backpressure: one buffered request per port; X_Busy high while pending or in flight, extra pulses dropped.
//
// Ports: Clock, Reset (async active-low); A_*/B_* requester ports (Lesen, Adresse in;
//        Daten, Fertig, Fehler, Busy out); SD_* reader interface; Aktiv one-hot grant;
//        zustand FSM state for debug.
// Optional: define SD_ARB_CACHE_EN for a one-entry read cache served through TREFFER.
module sd_arbiter
    import sd_arbiter_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        A_Lesen,
    input  logic [31:0] A_Adresse,
    output logic [31:0] A_Daten,
    output logic        A_Fertig,
    output logic        A_Fehler,
    output logic        A_Busy,
    input  logic        B_Lesen,
    input  logic [31:0] B_Adresse,
    output logic [31:0] B_Daten,
    output logic        B_Fertig,
    output logic        B_Fehler,
    output logic        B_Busy,
    output logic [31:0] SD_Adresse,
    output logic        SD_Lesen,
    input  logic [31:0] SD_Daten,
    input  logic        SD_Fertig,
    input  logic        SD_Busy,
    output logic [1:0]  Aktiv,
    output logic [2:0]  zustand
);

    zustand_t    state_q, state_d;

    logic        a_pend, b_pend;
    logic [31:0] a_adr, b_adr;
    logic        a_gew, b_gew;
    logic        a_frei, b_frei;

    logic        last_b_q;       // last served port: 1 = B
    logic        port_b_q;       // port currently being served: 1 = B
    logic        fertig_prev_q;
    logic [23:0] cnt_q;

    logic        any_pend, win_b, hit;
    logic [31:0] win_adr;
    logic        fertig_edge, tmo_reached;
    logic        grant, sd_grant, done, tmo;

    // ---------------------------------------------------------------
    // Request buffers
    // ---------------------------------------------------------------
    sd_arbiter_anfrage u_anfrage_a (
        .Clock    (Clock),
        .Reset    (Reset),
        .lesen    (A_Lesen),
        .adresse  (A_Adresse),
        .freigabe (a_frei),
        .gewaehrt (a_gew),
        .pending  (a_pend),
        .adr      (a_adr),
        .busy     (A_Busy)
    );

    sd_arbiter_anfrage u_anfrage_b (
        .Clock    (Clock),
        .Reset    (Reset),
        .lesen    (B_Lesen),
        .adresse  (B_Adresse),
        .freigabe (b_frei),
        .gewaehrt (b_gew),
        .pending  (b_pend),
        .adr      (b_adr),
        .busy     (B_Busy)
    );

    // ---------------------------------------------------------------
    // Arbitration: on a tie the port that was not served last wins.
    // ---------------------------------------------------------------
    assign any_pend    = a_pend | b_pend;
    assign win_b       = (a_pend && b_pend) ? ~last_b_q : b_pend;
    assign win_adr     = win_b ? b_adr : a_adr;
    assign fertig_edge = SD_Fertig & ~fertig_prev_q;

    // cnt_q counts cycles since the grant edge (1 in START), so the abort
    // fires TIMEOUT cycles after the grant decision.
    assign tmo_reached = (TIMEOUT != 24'd0) &&
                         (({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT});

`ifdef SD_ARB_CACHE_EN
    logic        cache_vld_q;
    logic [31:0] cache_adr_q;
    logic [31:0] cache_dat_q;

    assign hit = cache_vld_q && (cache_adr_q == win_adr);
`else
    assign hit = 1'b0;
`endif

    // Served-port flags; a cache hit has no Aktiv bit but still keeps the
    // port busy until its completion pulse.
    assign a_gew  = Aktiv[PORT_A] | ((state_q == ST_TREFFER) && !port_b_q);
    assign b_gew  = Aktiv[PORT_B] | ((state_q == ST_TREFFER) &&  port_b_q);
    assign a_frei = grant & ~win_b;
    assign b_frei = grant &  win_b;

    assign zustand = state_q;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Waiting for SD_Busy=0 also covers reader init and a sector
                // abandoned by reset.
                if (!SD_Busy && any_pend) begin
`ifdef SD_ARB_CACHE_EN
                    state_d = hit ? ST_TREFFER : ST_START;
`else
                    state_d = ST_START;
`endif
                end
            end
            ST_START: state_d = ST_LESEN;
            ST_LESEN: begin
                if (fertig_edge || tmo_reached) begin
                    state_d = ST_NACHLAUF;
                end
            end
            ST_NACHLAUF: begin
                if (!SD_Busy) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SD_ARB_CACHE_EN
            ST_TREFFER: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs / strobes
    // ---------------------------------------------------------------
    always_comb begin
        grant    = 1'b0;
        sd_grant = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        SD_Lesen = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!SD_Busy && any_pend) begin
                    grant    = 1'b1;
                    sd_grant = !hit;
                end
            end
            ST_START: SD_Lesen = 1'b1;
            ST_LESEN: begin
                // A completion edge in the same cycle as the limit still counts.
                if (fertig_edge) begin
                    done = 1'b1;
                end else if (tmo_reached) begin
                    tmo = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: grant bookkeeping, address, timeout counter, port results
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fertig_prev_q <= 1'b0;
            last_b_q      <= 1'b1;   // first tie goes to A
            port_b_q      <= 1'b0;
            cnt_q         <= 24'd0;
            Aktiv         <= AKTIV_KEINER;
            SD_Adresse    <= 32'd0;
            A_Daten       <= 32'd0;
            B_Daten       <= 32'd0;
            A_Fertig      <= 1'b0;
            B_Fertig      <= 1'b0;
            A_Fehler      <= 1'b0;
            B_Fehler      <= 1'b0;
        end else begin
            fertig_prev_q <= SD_Fertig;
            A_Fertig      <= 1'b0;
            B_Fertig      <= 1'b0;
            A_Fehler      <= 1'b0;
            B_Fehler      <= 1'b0;

            if (grant) begin
                last_b_q <= win_b;
                port_b_q <= win_b;
            end

            if (sd_grant) begin
                SD_Adresse <= win_adr;
                Aktiv      <= aktiv_von(win_b);
                cnt_q      <= 24'd1;
            end else if (state_q == ST_START || state_q == ST_LESEN) begin
                cnt_q <= cnt_q + 24'd1;
            end

            if (done) begin
                if (port_b_q) begin
                    B_Daten  <= SD_Daten;
                    B_Fertig <= 1'b1;
                end else begin
                    A_Daten  <= SD_Daten;
                    A_Fertig <= 1'b1;
                end
            end

            // Data stays untouched on abort; only the error pulse goes out.
            if (tmo) begin
                if (port_b_q) begin
                    B_Fehler <= 1'b1;
                end else begin
                    A_Fehler <= 1'b1;
                end
            end

            if (state_q == ST_NACHLAUF && !SD_Busy) begin
                Aktiv <= AKTIV_KEINER;
            end

`ifdef SD_ARB_CACHE_EN
            if (state_q == ST_TREFFER) begin
                if (port_b_q) begin
                    B_Daten  <= cache_dat_q;
                    B_Fertig <= 1'b1;
                end else begin
                    A_Daten  <= cache_dat_q;
                    A_Fertig <= 1'b1;
                end
            end
`endif
        end
    end

`ifdef SD_ARB_CACHE_EN
    // ---------------------------------------------------------------
    // One-entry cache: refreshed on every SD completion, dropped on abort.
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cache_vld_q <= 1'b0;
            cache_adr_q <= 32'd0;
            cache_dat_q <= 32'd0;
        end else if (tmo) begin
            cache_vld_q <= 1'b0;
        end else if (done) begin
            cache_vld_q <= 1'b1;
            cache_adr_q <= SD_Adresse;
            cache_dat_q <= SD_Daten;
        end
    end
`endif

endmodule

// File: tb/tb_sd_arbiter.sv
// Self-checking bench for sd_arbiter: behavioural SD reader plus directed and random request mixes.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_arbiter;

    localparam logic [23:0] TMO = 24'd100;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        A_Lesen = 1'b0, B_Lesen = 1'b0;
    logic [31:0] A_Adresse = 32'd0, B_Adresse = 32'd0;
    logic [31:0] A_Daten, B_Daten, SD_Adresse;
    logic        A_Fertig, A_Fehler, A_Busy, B_Fertig, B_Fehler, B_Busy;
    logic        SD_Lesen;
    logic [31:0] SD_Daten = 32'd0;
    logic        SD_Fertig = 1'b0, SD_Busy = 1'b0;
    logic [1:0]  Aktiv;
    logic [2:0]  zustand;

    sd_arbiter #(.TIMEOUT(TMO)) dut (
        .Clock(Clock), .Reset(Reset),
        .A_Lesen(A_Lesen), .A_Adresse(A_Adresse), .A_Daten(A_Daten),
        .A_Fertig(A_Fertig), .A_Fehler(A_Fehler), .A_Busy(A_Busy),
        .B_Lesen(B_Lesen), .B_Adresse(B_Adresse), .B_Daten(B_Daten),
        .B_Fertig(B_Fertig), .B_Fehler(B_Fehler), .B_Busy(B_Busy),
        .SD_Adresse(SD_Adresse), .SD_Lesen(SD_Lesen), .SD_Daten(SD_Daten),
        .SD_Fertig(SD_Fertig), .SD_Busy(SD_Busy),
        .Aktiv(Aktiv), .zustand(zustand)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Word memory behind the reader: fixed random content per address.
    logic [31:0] mem [logic [31:0]];

    // Reader model state.
    int          rd_t0, rd_lat, rd_sect;
    logic        rd_act = 1'b0, rd_nofert = 1'b0;
    logic [31:0] rd_adr;
    int          nxt_lat = 10, nxt_sect = 5;
    logic        nxt_nofert = 1'b0, rnd_param = 1'b0, init_busy = 1'b0;

    // Observation log.
    int          fert_port[$];
    logic [31:0] fert_dat[$];
    int          fert_cyc[$];
    int          fehl_port[$];
    int          fehl_cyc[$];
    int          lesen_cyc[$];
    logic [31:0] lesen_adr[$];
    int          acc_end[$];     // first SD_Busy-low cycle after each access

    // Round-robin reference: the port served most recently (1 = B).
    logic        model_last_b;
    int          exp_port[$];
    logic [31:0] exp_adr[$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic int count_port(input int p);
        int n = 0;
        foreach (fert_port[i]) if (fert_port[i] == p) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        fert_port.delete(); fert_dat.delete(); fert_cyc.delete();
        fehl_port.delete(); fehl_cyc.delete();
        lesen_cyc.delete(); lesen_adr.delete(); acc_end.delete();
    endtask

    // One clock: log DUT outputs of the new cycle, then drive the reader's inputs for it.
    task automatic step();
        logic b, f;
        @(posedge Clock);
        #1;
        cyc++;
        if (SD_Lesen === 1'b1) begin
            rd_t0 = cyc; rd_adr = SD_Adresse; rd_lat = nxt_lat; rd_sect = nxt_sect;
            rd_nofert = nxt_nofert; rd_act = 1'b1;
            lesen_cyc.push_back(cyc); lesen_adr.push_back(SD_Adresse);
            acc_end.push_back(rd_t0 + rd_lat + rd_sect + 1);
            if (rnd_param) begin
                nxt_lat  = $urandom_range(5, 40);
                nxt_sect = $urandom_range(1, 10);
            end
        end
        if (A_Fertig === 1'b1) begin fert_port.push_back(0); fert_dat.push_back(A_Daten); fert_cyc.push_back(cyc); end
        if (B_Fertig === 1'b1) begin fert_port.push_back(1); fert_dat.push_back(B_Daten); fert_cyc.push_back(cyc); end
        if (A_Fehler === 1'b1) begin fehl_port.push_back(0); fehl_cyc.push_back(cyc); end
        if (B_Fehler === 1'b1) begin fehl_port.push_back(1); fehl_cyc.push_back(cyc); end
        b = init_busy;
        f = 1'b0;
        if (rd_act) begin
            if (cyc > rd_t0 && cyc <= rd_t0 + rd_lat + rd_sect) b = 1'b1;
            if (!rd_nofert && cyc >= rd_t0 + rd_lat && cyc < rd_t0 + rd_lat + rd_sect) f = 1'b1;
        end
        SD_Busy   = b;
        SD_Fertig = f;
        SD_Daten  = f ? memval(rd_adr) : $urandom;
    endtask

    task automatic pulse(input logic a, input logic [31:0] aa, input logic b, input logic [31:0] ba);
        A_Lesen = a; A_Adresse = aa; B_Lesen = b; B_Adresse = ba;
        step();
        A_Lesen = 1'b0; B_Lesen = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        logic ok = 1'b0;
        while (n < budget && !ok) begin
            step();
            n++;
            ok = (zustand === 3'd0) && (SD_Busy === 1'b0) && (A_Busy === 1'b0) && (B_Busy === 1'b0);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step(); step();
        Reset = 1'b1;
        step();
    endtask

    initial begin
        int c0, t0, r, av, bv;
        logic [31:0] prev, ax;

        mem[32'h40] = 32'hDEADBEEF;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_aktiv",   {30'd0, Aktiv}, 32'd0);
        chk("rst_zustand", {29'd0, zustand}, 32'd0);
        chk("rst_sd_lesen", {31'd0, SD_Lesen}, 32'd0);
        chk("rst_sd_adr",  SD_Adresse, 32'd0);
        chk("rst_busy",    {30'd0, A_Busy, B_Busy}, 32'd0);
        chk("rst_fertig",  {28'd0, A_Fertig, B_Fertig, A_Fehler, B_Fehler}, 32'd0);
        chk("rst_daten",   A_Daten | B_Daten, 32'd0);
        Reset = 1'b1;
        step();

        // ---------------- single A read, 0x40, Fertig 50 after SD_Lesen ----------------
        clear_mon();
        nxt_lat = 50; nxt_sect = 20;
        c0 = cyc;
        pulse(1'b1, 32'h40, 1'b0, 32'd0);
        chk("t1_busy_c1", {31'd0, A_Busy}, 32'd1);
        chk("t1_nolesen_c1", {31'd0, SD_Lesen}, 32'd0);
        av = 0; bv = 0;
        repeat (120) begin
            step();
            if (SD_Busy === 1'b1) begin
                bv++;
                if (Aktiv !== 2'b01) av++;
            end
            // second A request while busy must vanish
            A_Lesen   = (cyc == c0 + 20);
            A_Adresse = 32'h99;
        end
        A_Lesen = 1'b0;
        wait_idle("t1_idle", 200);
        chk("t1_lesen_n",   lesen_cyc.size(), 1);
        if (lesen_cyc.size() > 0) chk("t1_lesen_cyc", lesen_cyc[0], c0 + 2);
        chk("t1_fert_n",    fert_port.size(), 1);
        if (fert_port.size() > 0) begin
            chk("t1_fert_port", fert_port[0], 0);
            chk("t1_fert_cyc",  fert_cyc[0], c0 + 2 + 50 + 1);
            chk("t1_fert_dat",  fert_dat[0], 32'hDEADBEEF);
        end
        chk("t1_aktiv_busy", av, 0);
        chk("t1_busy_seen", {31'd0, bv > 0}, 32'd1);
        chk("t1_aktiv_idle", {30'd0, Aktiv}, 32'd0);
        chk("t1_daten_hold", A_Daten, 32'hDEADBEEF);

        // ---------------- simultaneous requests, round robin ----------------
        do_reset();
        clear_mon();
        rnd_param = 1'b1;
        nxt_lat = 20; nxt_sect = 6;
        pulse(1'b1, 32'h10, 1'b1, 32'h20);
        wait_idle("t2_idle1", 400);
        ax = 32'h200 + 4 * $urandom_range(0, 15);
        pulse(1'b1, ax, 1'b0, 32'd0);
        wait_idle("t2_idle2", 400);
        pulse(1'b1, 32'h30, 1'b1, 32'h34);
        wait_idle("t2_idle3", 400);
        chk("t2_n", fert_port.size(), 5);
        exp_port = '{0, 1, 0, 1, 0};
        exp_adr  = '{32'h10, 32'h20, ax, 32'h34, 32'h30};
        for (int k = 0; k < 5 && k < fert_port.size(); k++) begin
            chk($sformatf("t2_port%0d", k), fert_port[k], exp_port[k]);
            chk($sformatf("t2_dat%0d", k), fert_dat[k], memval(exp_adr[k]));
        end
        if (lesen_adr.size() >= 2 && acc_end.size() >= 1) begin
            chk("t2_sdadr0", lesen_adr[0], 32'h10);
            chk("t2_sdadr1", lesen_adr[1], 32'h20);
            chk("t2_spacing", lesen_cyc[1], acc_end[0] + 2);
        end else begin
            chk("t2_lesen_n", lesen_adr.size(), 5);
        end

        // ---------------- reader busy during init ----------------
        clear_mon();
        init_busy = 1'b1; SD_Busy = 1'b1;
        pulse(1'b1, 32'h44, 1'b0, 32'd0);
        av = 0;
        repeat (30) begin
            step();
            if (A_Busy !== 1'b1) av++;
        end
        chk("t3_busy_held", av, 0);
        chk("t3_no_lesen", lesen_cyc.size(), 0);
        init_busy = 1'b0; SD_Busy = 1'b0;
        r = cyc;
        wait_idle("t3_idle", 300);
        if (lesen_cyc.size() > 0) chk("t3_lesen_cyc", lesen_cyc[0], r + 1);
        chk("t3_fert_n", count_port(0), 1);
        if (fert_dat.size() > 0) chk("t3_dat", fert_dat[0], memval(32'h44));

        // ---------------- timeout, Fertig never comes ----------------
        clear_mon();
        rnd_param = 1'b0;
        prev = A_Daten;
        nxt_nofert = 1'b1; nxt_lat = 100; nxt_sect = 50;
        c0 = cyc;
        pulse(1'b1, 32'h48, 1'b0, 32'd0);
        while (lesen_cyc.size() == 0 && cyc < c0 + 10) step();
        nxt_nofert = 1'b0; nxt_lat = 20; nxt_sect = 5;
        while (cyc < c0 + 110) step();
        pulse(1'b0, 32'd0, 1'b1, 32'h4C);
        wait_idle("t4_idle", 500);
        chk("t4_fehl_n", fehl_cyc.size(), 1);
        if (fehl_cyc.size() > 0) begin
            chk("t4_fehl_cyc",  fehl_cyc[0], c0 + 1 + int'(TMO));
            chk("t4_fehl_port", fehl_port[0], 0);
        end
        chk("t4_no_afert", count_port(0), 0);
        chk("t4_daten_kept", A_Daten, prev);
        chk("t4_b_fert", count_port(1), 1);
        if (lesen_cyc.size() >= 2) chk("t4_no_early_grant", lesen_cyc[1], acc_end[0] + 2);
        else chk("t4_lesen_n", lesen_cyc.size(), 2);

        // ---------------- reset during LESEN ----------------
        clear_mon();
        nxt_lat = 60; nxt_sect = 10;
        c0 = cyc;
        pulse(1'b1, 32'h50, 1'b0, 32'd0);
        while (lesen_cyc.size() == 0 && cyc < c0 + 10) step();
        t0 = (lesen_cyc.size() > 0) ? lesen_cyc[0] : cyc;
        nxt_lat = 15; nxt_sect = 5;
        pulse(1'b0, 32'd0, 1'b1, 32'h54);   // B left pending, must be wiped by reset
        while (cyc < t0 + 10) step();
        Reset = 1'b0;
        #1;
        chk("t5_rst_aktiv", {30'd0, Aktiv}, 32'd0);
        chk("t5_rst_zustand", {29'd0, zustand}, 32'd0);
        chk("t5_rst_busy", {30'd0, A_Busy, B_Busy}, 32'd0);
        chk("t5_rst_sd", {31'd0, SD_Lesen}, 32'd0);
        chk("t5_rst_daten", A_Daten | B_Daten, 32'd0);
        step(); step(); step();
        Reset = 1'b1;
        pulse(1'b1, 32'h80, 1'b0, 32'd0);
        wait_idle("t5_idle", 400);
        chk("t5_lesen_n", lesen_cyc.size(), 2);
        if (lesen_cyc.size() >= 2) chk("t5_lesen_cyc", lesen_cyc[1], acc_end[0] + 1);
        chk("t5_fert_n", fert_port.size(), 1);
        if (fert_port.size() > 0) begin
            chk("t5_port", fert_port[0], 0);
            chk("t5_dat", fert_dat[0], memval(32'h80));
        end

        // ---------------- repeated read of 0x40 (cache or not) ----------------
        clear_mon();
        nxt_lat = 12; nxt_sect = 4;
        pulse(1'b1, 32'h40, 1'b0, 32'd0);
        wait_idle("t6_idle1", 200);
        c0 = cyc;
        pulse(1'b1, 32'h40, 1'b0, 32'd0);
        wait_idle("t6_idle2", 200);
        chk("t6_fert_n", fert_port.size(), 2);
        if (fert_port.size() >= 2) chk("t6_dat2", fert_dat[1], 32'hDEADBEEF);
`ifdef SD_ARB_CACHE_EN
        chk("t6_lesen_n", lesen_cyc.size(), 1);
        if (fert_cyc.size() >= 2) chk("t6_hit_cyc", fert_cyc[1], c0 + 3);
`else
        chk("t6_lesen_n", lesen_cyc.size(), 2);
        if (lesen_cyc.size() >= 2) chk("t6_lesen_cyc", lesen_cyc[1], c0 + 2);
        if (fert_cyc.size() >= 2) chk("t6_fert_cyc", fert_cyc[1], c0 + 2 + 12 + 1);
`endif

        // ---------------- random request mixes vs round-robin model ----------------
        do_reset();
        model_last_b = 1'b1;
        rnd_param = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int m;
            logic [31:0] aa, ba;
            clear_mon();
            exp_port.delete(); exp_adr.delete();
            m  = $urandom_range(1, 3);
            aa = 32'h100 + 4 * $urandom_range(0, 3);
            ba = 32'h100 + 4 * $urandom_range(0, 3);
            if (m == 3) begin
                if (model_last_b) begin
                    exp_port.push_back(0); exp_adr.push_back(aa);
                    exp_port.push_back(1); exp_adr.push_back(ba);
                end else begin
                    exp_port.push_back(1); exp_adr.push_back(ba);
                    exp_port.push_back(0); exp_adr.push_back(aa);
                end
            end else if (m == 1) begin
                exp_port.push_back(0); exp_adr.push_back(aa);
            end else begin
                exp_port.push_back(1); exp_adr.push_back(ba);
            end
            model_last_b = (exp_port[exp_port.size() - 1] == 1);
            pulse(m[0], aa, m[1], ba);
            wait_idle($sformatf("rnd%0d_idle", it), 400);
            chk($sformatf("rnd%0d_n", it), fert_port.size(), exp_port.size());
            for (int k = 0; k < exp_port.size() && k < fert_port.size(); k++) begin
                chk($sformatf("rnd%0d_port%0d", it, k), fert_port[k], exp_port[k]);
                chk($sformatf("rnd%0d_dat%0d", it, k), fert_dat[k], memval(exp_adr[k]));
            end
            chk($sformatf("rnd%0d_fehler", it), fehl_cyc.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
